// File: rtl/id_inst_buffer_if.sv
// Fetch-to-decode instruction handshake bundle.
// The buffer takes the slave view; the fetch/decode side takes the master view.
interface id_inst_buffer_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/id_inst_buffer.sv
// Instruction queue between fetch and decode. It is a strict FIFO with no
// bypass. On a branch redirect it can keep the delay-slot instruction, and it
// counts the cycles in which decode holds back a valid head entry.
module id_inst_buffer #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int KEEP_DS = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    id_inst_buffer_if.slave          bus,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ds_wait,
    output logic [CNT_W-1:0]         stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic {NORMAL = 1'b0, DS_WAIT = 1'b1} state_t;

    state_t            state;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    logic              enq;
    logic              deq;
    logic              flush_n;
    logic              mem_we;
    logic [PTR_W-1:0]  rd_adv;
    logic [CW-1:0]     rem;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Handshake decode, pointer look-ahead and head presentation.
    always_comb begin
        bus.in_ready  = (count != CW'(DEPTH));
        bus.out_valid = (count != '0);
        bus.out_pc    = bus.out_valid ? mem_pc[rd_ptr]   : '0;
        bus.out_inst  = bus.out_valid ? mem_inst[rd_ptr] : '0;
        enq     = bus.in_valid & bus.in_ready;
        deq     = bus.out_valid & bus.out_ready;
        flush_n = flush & (state == NORMAL);
        rd_adv  = rd_ptr + PTR_W'(deq);
        rem     = count - CW'(deq);
        // A redirect drops the incoming word. The exception is a delay slot
        // that arrives when nothing older is left to serve as the delay slot.
        mem_we  = enq & (~flush_n | ((KEEP_DS != 0) & (rem == '0)));
    end

    assign ds_wait = (state == DS_WAIT);

    // Queue storage: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_pc[wr_ptr]   <= bus.in_pc;
            mem_inst[wr_ptr] <= bus.in_inst;
        end
    end

    // Control: pointers, occupancy, redirect state machine and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NORMAL;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.out_valid & ~bus.out_ready)
                stall_cnt <= sat_inc(stall_cnt);
            rd_ptr <= rd_adv;
            if (flush_n) begin
                if (KEEP_DS == 0) begin
                    wr_ptr <= rd_adv;
                    count  <= '0;
                end else if (rem != '0) begin
                    // The oldest surviving entry is the delay slot; drop the rest.
                    wr_ptr <= rd_adv + PTR_W'(1);
                    count  <= CW'(1);
                end else if (enq) begin
                    // Queue drained this cycle; the arriving word is the delay slot.
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    count  <= CW'(1);
                end else begin
                    // Nothing left yet: hold for the delay slot still in flight.
                    count  <= '0;
                    state  <= DS_WAIT;
                end
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                count <= count + CW'(enq) - CW'(deq);
                if ((state == DS_WAIT) && enq)
                    state <= NORMAL;
            end
        end
    end
endmodule
